block_dot_acc: RTL and testbench
================================

Name: block_dot_acc

Overview:
- Streaming accumulator that sits directly downstream of the block multiplier.
- Consumes one product block per handshake: shared exponent bias plus LENGTH minifloats.
- Reduces each block to a signed fixed-point partial sum, scales it by the block's shared exponent, and accumulates across a packet.
- Emits the dot-product result when the packet's last block is accumulated.

Parameters:
- EXP_BIAS, 8: width of the shared-exponent field of a block.
- LENGTH, 4: minifloats per block.
- SIZE, 8: bits per minifloat.
- NEXP, 4: exponent bits per minifloat. NMAN = SIZE-1-NEXP (derived).
- ACC_W, 48: signed accumulator/result width, in units of 2^-NMAN.
- CNT_W, 16: width of the block counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  upstream block valid.
- in_ready  out  1  block accepted when in_valid&in_ready.
- in_block  in  EXP_BIAS+LENGTH*SIZE  {expBias, elements}; element i at [i*SIZE +: SIZE].
- in_last  in  1  block is final of packet; sampled with in_block.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts result.
- out_acc  out  ACC_W  signed packet sum.
- out_ovf  out  1  saturation occurred within packet.
- out_count  out  CNT_W  blocks accumulated in packet.

Behaviour:
- Single clock clk. Reset is synchronous and active-high (rst).
- Reset clears s1_valid, out_valid, acc, ovf_sticky, count, out_acc, out_ovf and out_count to 0. A reset mid-packet discards all partial state. No output is produced for the discarded packet.
- Element decode: sign=[SIZE-1], e=[SIZE-2 -: NEXP], m=[NMAN-1:0].
  - sig = {e!=0, m}.
  - magnitude = sig << (e==0 ? 0 : e-1).
  - The value is negated when sign=1.
- Partial sum P = signed sum of the LENGTH element values, computed at full width with no loss.
- Stage S1 (registered): P, expBias, last and s1_valid.
- Stage S2: term = P << expBias, computed exactly.
  - If expBias>=ACC_W with P!=0, or term is outside the signed ACC_W range, term saturates to +/-(2^(ACC_W-1)) (max positive 2^(ACC_W-1)-1) and ovf_sticky is set.
- Accumulation: sum = acc + term, saturating in the same way and also setting ovf_sticky on saturation.
- S1 advance rule: S1 advances every cycle s1_valid=1, except when s1_last=1 and out_valid=1 and out_ready=0 (stall).
- in_ready = !s1_valid | advance. The path is combinational from out_valid/out_ready.
- On a non-last advance:
  - acc <= sum.
  - count <= count+1, saturating at all-ones.
- On a last advance:
  - out_acc <= sum, out_ovf <= ovf_sticky|this-cycle saturation, out_count <= count+1 (saturating), out_valid <= 1.
  - acc, count and ovf_sticky clear to 0 in the same cycle.
- out_valid clears on out_ready when no new last advance occurs that cycle. A simultaneous release and new last reloads the output register, and out_valid stays 1.
- Latency: a block accepted at edge N is in S1 after N. Its last result is visible (out_valid=1) after edge N+1.
- Throughput: one block per cycle with no bubbles while the output is not stalled.
- Single-block packets (in_last on the first block) are legal.
- A zero block contributes 0 and is still counted.

Test Plan:
- Single block, expBias=0, elements 0x08 x4, last → out_acc=32, out_count=1, out_ovf=0, out_valid one edge after S1 load.
- Block A expBias=2 with 0x08 x4, then block B expBias=0 with 0x88 x4 and last, back-to-back → out_acc=128-32=96, out_count=2, in_ready never drops.
- Subnormals: elements 0x05,0x05,0x00,0x85, expBias=1, last → out_acc=(5+5+0-5)<<1=10.
- Output stall: hold out_ready=0 with two single-block packets queued. Required response:
  - in_ready drops while the second last sits in S1.
  - First result is held stable.
  - Releasing out_ready for 1 cycle delivers the second result next cycle with out_valid continuous.
- Overflow: expBias=60, element 0x08 x4, last → out_acc=2^47-1, out_ovf=1. The next packet of 0x08 x4 at expBias=0 gives out_acc=32, out_ovf=0 (sticky cleared).
- Reset mid-packet: accept 2 non-last blocks, assert rst for 1 cycle, then send 0x08 x4 last at expBias=0 → out_acc=32, out_count=1.

Source files
------------

// File: rtl/block_dot_acc.sv
// Streaming block dot-product accumulator: decodes one block of minifloat
// products per handshake, scales the partial sum by the block's shared
// exponent and accumulates with saturation until the packet's last block.
module block_dot_acc #(
  parameter int EXP_BIAS = 8,
  parameter int LENGTH   = 4,
  parameter int SIZE     = 8,
  parameter int NEXP     = 4,
  parameter int ACC_W    = 48,
  parameter int CNT_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [EXP_BIAS+LENGTH*SIZE-1:0]  in_block,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [ACC_W-1:0]          out_acc,
  output logic                             out_ovf,
  output logic [CNT_W-1:0]                 out_count
);

  localparam int NMAN  = SIZE - 1 - NEXP;
  // Widest element magnitude: (NMAN+1)-bit significand shifted by up to 2^NEXP-2.
  localparam int MAG_W = NMAN + 1 + (1 << NEXP) - 2;
  // Signed sum of LENGTH magnitudes, with one spare bit of headroom.
  localparam int P_W   = MAG_W + 2 + $clog2(LENGTH);
  // Wide enough to hold P shifted by any amount below ACC_W without loss.
  localparam int T_W   = P_W + ACC_W;
  localparam int BLK_W = EXP_BIAS + LENGTH * SIZE;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Element decode: sign-magnitude minifloat to exact signed fixed point.
  logic signed [P_W-1:0] elem_val [LENGTH];

  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_elem
    logic [SIZE-1:0] el;
    logic [NEXP-1:0] ex;
    logic            e_nz;
    logic [NEXP-1:0] sh;
    logic [P_W-1:0]  mag;

    assign el   = in_block[gi*SIZE +: SIZE];
    assign ex   = el[SIZE-2 -: NEXP];
    assign e_nz = |ex;
    assign sh   = e_nz ? (ex - NEXP'(1)) : '0;
    assign mag  = {{(P_W-NMAN-1){1'b0}}, e_nz, el[NMAN-1:0]} << sh;
    assign elem_val[gi] = el[SIZE-1] ? -$signed(mag) : $signed(mag);
  end

  // Exact partial sum of the block's elements.
  logic signed [P_W-1:0] p_sum;
  always_comb begin
    p_sum = '0;
    for (int i = 0; i < LENGTH; i++) begin
      p_sum = p_sum + elem_val[i];
    end
  end

  // Stage S1 registers and control.
  logic                  s1_valid;
  logic signed [P_W-1:0] s1_p;
  logic [EXP_BIAS-1:0]   s1_exp;
  logic                  s1_last;
  logic signed [ACC_W-1:0] acc;
  logic                  ovf_sticky;
  logic [CNT_W-1:0]      count;

  logic advance;
  logic accept;

  // The only stall is a finished packet waiting behind an unread result.
  assign advance  = s1_valid & ~(s1_last & out_valid & ~out_ready);
  assign in_ready = ~s1_valid | advance;
  assign accept   = in_valid & in_ready;

  // S1 pipeline register: loads on accept, empties when it advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_exp   <= '0;
      s1_last  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_p     <= p_sum;
      s1_exp   <= in_block[BLK_W-1 -: EXP_BIAS];
      s1_last  <= in_last;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: scale by the shared exponent, saturating to the accumulator range.
  logic signed [T_W-1:0]   p_ext;
  logic signed [T_W-1:0]   shifted;
  logic signed [ACC_W-1:0] term;
  logic                    term_sat;
  always_comb begin
    term     = '0;
    term_sat = 1'b0;
    p_ext    = {{ACC_W{s1_p[P_W-1]}}, s1_p};
    shifted  = p_ext << s1_exp;
    if (s1_p == '0) begin
      term = '0;
    end else if ((32'(s1_exp) >= ACC_W) ||
                 (shifted[T_W-1:ACC_W-1] != {(P_W+1){shifted[T_W-1]}})) begin
      term_sat = 1'b1;
      term     = s1_p[P_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      term = shifted[ACC_W-1:0];
    end
  end

  // Saturating accumulate of the scaled term.
  logic [ACC_W:0]          sum_wide;
  logic                    sum_sat;
  logic signed [ACC_W-1:0] sum;
  logic                    cycle_sat;
  logic [CNT_W-1:0]        count_inc;
  always_comb begin
    sum_wide  = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    sum_sat   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum       = sum_sat ? (sum_wide[ACC_W] ? SAT_MIN : SAT_MAX) : sum_wide[ACC_W-1:0];
    cycle_sat = term_sat | sum_sat;
    count_inc = (&count) ? count : count + CNT_W'(1);
  end

  // Packet accumulator state: builds up on non-last blocks, clears on last.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      count      <= '0;
    end else if (advance) begin
      if (s1_last) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
        count      <= '0;
      end else begin
        acc        <= sum;
        ovf_sticky <= ovf_sticky | cycle_sat;
        count      <= count_inc;
      end
    end
  end

  // Result register: loaded by a last advance, held until taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (advance && s1_last) begin
      out_valid <= 1'b1;
      out_acc   <= sum;
      out_ovf   <= ovf_sticky | cycle_sat;
      out_count <= count_inc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_dot_acc.sv
// Self-checking bench for block_dot_acc: directed scenarios plus randomized
// packets checked against an arithmetic model of the block dot product.
module tb_block_dot_acc;

  localparam int ACC_W = 48;
  localparam int CNT_W = 16;
  localparam int BW    = 40;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [BW-1:0]           in_block;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_ovf;
  logic [CNT_W-1:0]        out_count;

  block_dot_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_seen = 0;

  // Reference model state for the packet in progress.
  logic signed [127:0] m_acc;
  bit                  m_ovf;
  int                  m_cnt;

  localparam logic signed [127:0] MAXV = (128'sd1 <<< (ACC_W-1)) - 128'sd1;
  localparam logic signed [127:0] MINV = -(128'sd1 <<< (ACC_W-1));

  // Output collector and input-stall observer.
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back(res_t'({out_acc, out_ovf, out_count}));
    if (in_valid && !in_ready) stall_seen++;
  end

  // Value of one minifloat in units of 2^-3: sig * 2^(e-1), subnormal sig = m.
  function automatic longint elem_value(input logic [7:0] x);
    int     e;
    longint sig;
    longint v;
    e = int'(x[6:3]);
    if (e == 0) v = longint'(x[2:0]);
    else begin
      sig = 8 + longint'(x[2:0]);
      v   = sig * (longint'(1) << (e - 1));
    end
    return x[7] ? -v : v;
  endfunction

  task automatic clamp(inout logic signed [127:0] v, inout bit sat);
    if (v > MAXV) begin v = MAXV; sat = 1'b1; end
    else if (v < MINV) begin v = MINV; sat = 1'b1; end
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_block(input logic [BW-1:0] blk, input bit last);
    longint              p;
    int                  eb;
    logic signed [127:0] t;
    logic signed [127:0] s;
    bit                  sat;
    res_t                r;
    p   = 0;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) p += elem_value(blk[i*8 +: 8]);
    eb = int'(blk[39:32]);
    if (p == 0) t = '0;
    else if (eb >= ACC_W) begin
      t   = (p < 0) ? MINV : MAXV;
      sat = 1'b1;
    end else begin
      t = p;
      t = t * (128'sd1 <<< eb);
      clamp(t, sat);
    end
    s = m_acc + t;
    clamp(s, sat);
    if (last) begin
      r.acc = s[ACC_W-1:0];
      r.ovf = m_ovf | sat;
      r.cnt = (m_cnt + 1 > 65535) ? 16'hFFFF : CNT_W'(m_cnt + 1);
      exp_q.push_back(r);
      model_clear();
    end else begin
      m_acc = s;
      m_ovf = m_ovf | sat;
      m_cnt = m_cnt + 1;
    end
  endtask

  function automatic logic [BW-1:0] mk4(input logic [7:0] eb, input logic [7:0] x);
    return {eb, x, x, x, x};
  endfunction

  // Offer one block starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [BW-1:0] blk, input bit last);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_block = blk;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept: in_ready=%0b required 1 within 100 cycles", in_ready);
    end else begin
      model_block(blk, last);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for every expected result and compare in order.
  task automatic wait_results(input string name);
    int   n;
    int   t;
    res_t e;
    res_t g;
    n = exp_q.size();
    t = 0;
    while (got_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("FAIL %s_count: results=%0d required %0d", name, got_q.size(), n);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s_result: acc=%0d ovf=%0b count=%0d required acc=%0d ovf=%0b count=%0d",
                 name, $signed(g.acc), g.ovf, g.cnt, $signed(e.acc), e.ovf, e.cnt);
      end else begin
        $display("%s: acc=%0d ovf=%0b count=%0d ok", name, $signed(g.acc), g.ovf, g.cnt);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_block  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    got_q.delete();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++;
    if (out_acc !== '0) begin errors++; $display("FAIL reset_out_acc: got %0d required 0", out_acc); end
    checks++;
    if (out_count !== '0) begin errors++; $display("FAIL reset_out_count: got %0d required 0", out_count); end
    checks++;
    if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %0b required 0", out_ovf); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    $display("reset: done");
  endtask

  task automatic test_single();
    send(mk4(8'd0, 8'h08), 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b required 0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid=%0b required 1", out_valid); end
    checks++;
    if (out_acc !== 48'sd32) begin errors++; $display("FAIL single_acc: got %0d required 32", out_acc); end
    wait_results("single");
  endtask

  task automatic test_back_to_back();
    stall_seen = 0;
    send(mk4(8'd2, 8'h08), 1'b0);
    send(mk4(8'd0, 8'h88), 1'b1);
    checks++;
    if (stall_seen != 0) begin errors++; $display("FAIL b2b_in_ready: stalled cycles=%0d required 0", stall_seen); end
    wait_results("back_to_back");
  endtask

  task automatic test_subnormal();
    send({8'd1, 8'h85, 8'h00, 8'h05, 8'h05}, 1'b1);
    wait_results("subnormal");
  endtask

  task automatic test_overflow();
    send(mk4(8'd60, 8'h08), 1'b1);
    send(mk4(8'd0, 8'h08), 1'b1);
    wait_results("overflow");
  endtask

  task automatic test_stall();
    res_t e1;
    res_t e2;
    out_ready = 1'b0;
    send(mk4(8'd0, 8'h10), 1'b1);
    send(mk4(8'd0, 8'h08), 1'b1);
    e1 = exp_q[0];
    e2 = exp_q[1];
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %0b required 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_acc !== $signed(e1.acc)) begin
        errors++;
        $display("FAIL stall_hold: valid=%0b acc=%0d required valid=1 acc=%0d", out_valid, out_acc, $signed(e1.acc));
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_acc !== $signed(e2.acc)) begin
      errors++;
      $display("FAIL stall_release: valid=%0b acc=%0d required valid=1 acc=%0d", out_valid, out_acc, $signed(e2.acc));
    end
    out_ready = 1'b1;
    wait_results("stall");
  endtask

  task automatic test_reset_mid();
    send(mk4(8'd3, 8'h08), 1'b0);
    send(mk4(8'd1, 8'h18), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    send(mk4(8'd0, 8'h08), 1'b1);
    wait_results("reset_mid");
  endtask

  bit bp_on;

  task automatic test_random();
    int nblk;
    logic [7:0] eb;
    logic [BW-1:0] blk;
    bp_on = 1'b1;
    fork
      begin
        while (bp_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int p = 0; p < 25; p++) begin
      nblk = int'($urandom_range(1, 4));
      for (int b = 0; b < nblk; b++) begin
        if ($urandom_range(0, 9) < 8) eb = 8'($urandom_range(0, 12));
        else eb = 8'($urandom_range(13, 255));
        blk = {eb, 32'($urandom)};
        send(blk, b == nblk - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    bp_on = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_results("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_subnormal();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
